// File: rtl/pc_hazard_control.sv
// -----------------------------------------------------------------------------
// pc_hazard_control
//   Selects the next PC value and drives the pipeline freeze, flush and bubble
//   controls. It handles load-use hazards (with a configurable stall length),
//   jumps, taken branches and an external halt/resume request.
//
// Parameters
//   LOAD_STALL_CYCLES  stalled cycles per load-use hazard (1..7)
//
// Ports
//   Clk                 rising-edge clock
//   Reset               asynchronous active-high reset
//   PCResult     [31:0] current PC register value
//   EX_MemRead          EX instruction is a load
//   EX_Rt        [4:0]  destination register of the EX load
//   ID_Rs, ID_Rt [4:0]  source registers of the ID instruction
//   ID_UsesRt           ID instruction reads Rt
//   ID_BranchTaken      branch in ID resolved taken
//   ID_BranchTarget     branch target address
//   ID_Jump             jump in ID
//   ID_JumpTarget       jump target address
//   Halt, Resume        pipeline freeze request / release
//   NextPC       [31:0] address presented to the PC register
//   PCWrite_Disable     freezes the PC register
//   IFID_Write_Disable  freezes the IF/ID register
//   IFID_Flush          zeroes the IF/ID register on the next edge
//   IDEX_Bubble         inserts a NOP into ID/EX on the next edge
//   Halted              high while halted
//   StallCount   [15:0] saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module pc_hazard_control #(
   parameter int LOAD_STALL_CYCLES = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] PCResult,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_Rt,
   input  logic [4:0]  ID_Rs,
   input  logic [4:0]  ID_Rt,
   input  logic        ID_UsesRt,
   input  logic        ID_BranchTaken,
   input  logic [31:0] ID_BranchTarget,
   input  logic        ID_Jump,
   input  logic [31:0] ID_JumpTarget,
   input  logic        Halt,
   input  logic        Resume,
   output logic [31:0] NextPC,
   output logic        PCWrite_Disable,
   output logic        IFID_Write_Disable,
   output logic        IFID_Flush,
   output logic        IDEX_Bubble,
   output logic        Halted,
   output logic [15:0] StallCount
);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_STALL = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t     state;
   logic [2:0] stall_cnt;
   logic       hazard;
   logic       stalling;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Register 0 is hard-wired, so a load to it never creates a dependency.
   assign hazard = EX_MemRead && (EX_Rt != 5'd0) &&
                   ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

   assign Halted = (state == S_HALT);

   always_comb begin
      NextPC             = PCResult + 32'd4;
      PCWrite_Disable    = 1'b0;
      IFID_Write_Disable = 1'b0;
      IFID_Flush         = 1'b0;
      IDEX_Bubble        = 1'b0;
      stalling           = 1'b0;
      if (Reset) begin
         NextPC = 32'h0000_0000;
      end else begin
         case (state)
            S_RUN: begin
               if (Halt || hazard) begin
                  NextPC             = PCResult;
                  PCWrite_Disable    = 1'b1;
                  IFID_Write_Disable = 1'b1;
                  IDEX_Bubble        = 1'b1;
                  stalling           = !Halt;
               end else if (ID_Jump) begin
                  NextPC     = ID_JumpTarget;
                  IFID_Flush = 1'b1;
               end else if (ID_BranchTaken) begin
                  NextPC     = ID_BranchTarget;
                  IFID_Flush = 1'b1;
               end
            end
            S_STALL, S_HALT: begin
               // All redirect and hazard inputs are ignored while frozen.
               NextPC             = PCResult;
               PCWrite_Disable    = 1'b1;
               IFID_Write_Disable = 1'b1;
               IDEX_Bubble        = 1'b1;
               stalling           = (state == S_STALL);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= S_RUN;
         stall_cnt  <= 3'd0;
         StallCount <= 16'd0;
      end else begin
         if (stalling)
            StallCount <= sat_inc16(StallCount);
         case (state)
            S_RUN: begin
               if (Halt) begin
                  state <= S_HALT;
               end else if (hazard && (LOAD_STALL_CYCLES > 1)) begin
                  // The RUN cycle is the first stalled cycle; STALL covers the rest.
                  state     <= S_STALL;
                  stall_cnt <= 3'(LOAD_STALL_CYCLES - 1);
               end
            end
            S_STALL: begin
               if (stall_cnt == 3'd1) begin
                  state     <= S_RUN;
                  stall_cnt <= 3'd0;
               end else begin
                  stall_cnt <= stall_cnt - 3'd1;
               end
            end
            S_HALT: begin
               if (Resume && !Halt)
                  state <= S_RUN;
            end
            default: begin
               state     <= S_RUN;
               stall_cnt <= 3'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_hazard_control.sv
module tb_pc_hazard_control;

   logic        Clk;
   logic        Reset;
   logic [31:0] PCResult;
   logic        EX_MemRead;
   logic [4:0]  EX_Rt, ID_Rs, ID_Rt;
   logic        ID_UsesRt, ID_BranchTaken, ID_Jump, Halt, Resume;
   logic [31:0] ID_BranchTarget, ID_JumpTarget;

   logic [31:0] npc1, npc3;
   logic        pcw1, ifw1, fl1, bub1, hlt1;
   logic        pcw3, ifw3, fl3, bub3, hlt3;
   logic [15:0] sc1, sc3;

   // Packed view: {NextPC, PCWrite_Disable, IFID_Write_Disable, IFID_Flush, IDEX_Bubble, Halted, StallCount}
   logic [52:0] o1, o3;
   assign o1 = {npc1, pcw1, ifw1, fl1, bub1, hlt1, sc1};
   assign o3 = {npc3, pcw3, ifw3, fl3, bub3, hlt3, sc3};

   int asserts = 0;
   int fails   = 0;

   pc_hazard_control #(.LOAD_STALL_CYCLES(1)) dut1 (
      .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .EX_MemRead(EX_MemRead),
      .EX_Rt(EX_Rt), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
      .ID_BranchTaken(ID_BranchTaken), .ID_BranchTarget(ID_BranchTarget),
      .ID_Jump(ID_Jump), .ID_JumpTarget(ID_JumpTarget), .Halt(Halt), .Resume(Resume),
      .NextPC(npc1), .PCWrite_Disable(pcw1), .IFID_Write_Disable(ifw1),
      .IFID_Flush(fl1), .IDEX_Bubble(bub1), .Halted(hlt1), .StallCount(sc1));

   pc_hazard_control #(.LOAD_STALL_CYCLES(3)) dut3 (
      .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .EX_MemRead(EX_MemRead),
      .EX_Rt(EX_Rt), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
      .ID_BranchTaken(ID_BranchTaken), .ID_BranchTarget(ID_BranchTarget),
      .ID_Jump(ID_Jump), .ID_JumpTarget(ID_JumpTarget), .Halt(Halt), .Resume(Resume),
      .NextPC(npc3), .PCWrite_Disable(pcw3), .IFID_Write_Disable(ifw3),
      .IFID_Flush(fl3), .IDEX_Bubble(bub3), .Halted(hlt3), .StallCount(sc3));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- behavioural reference model ----------------
   // Per instance: halted flag, number of forced stall cycles still owed,
   // and the stall-cycle tally.
   int ls[2] = '{1, 3};
   bit m_halt[2];
   int m_left[2];
   int m_cnt[2];

   function automatic bit load_use();
      return EX_MemRead && (EX_Rt != 0) &&
             ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
   endfunction

   function automatic logic [52:0] expect_out(int i);
      logic [31:0] npc;
      logic [4:0]  c;
      if (Reset) return 53'd0;
      npc = PCResult + 32'd4;
      c   = 5'b00000;
      if (m_halt[i]) begin
         npc = PCResult; c = 5'b11011;
      end else if (m_left[i] > 0 || Halt || load_use()) begin
         npc = PCResult; c = 5'b11010;
      end else if (ID_Jump) begin
         npc = ID_JumpTarget; c = 5'b00100;
      end else if (ID_BranchTaken) begin
         npc = ID_BranchTarget; c = 5'b00100;
      end
      return {npc, c, 16'(m_cnt[i])};
   endfunction

   always @(posedge Clk or posedge Reset) begin
      for (int i = 0; i < 2; i++) begin
         if (Reset) begin
            m_halt[i] <= 1'b0; m_left[i] <= 0; m_cnt[i] <= 0;
         end else if (m_halt[i]) begin
            if (Resume && !Halt) m_halt[i] <= 1'b0;
         end else if (m_left[i] > 0) begin
            m_left[i] <= m_left[i] - 1;
            m_cnt[i]  <= (m_cnt[i] >= 65535) ? 65535 : m_cnt[i] + 1;
         end else if (Halt) begin
            m_halt[i] <= 1'b1;
         end else if (load_use()) begin
            m_left[i] <= ls[i] - 1;
            m_cnt[i]  <= (m_cnt[i] >= 65535) ? 65535 : m_cnt[i] + 1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_inputs();
      EX_MemRead = 0; EX_Rt = 0; ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0;
      ID_BranchTaken = 0; ID_BranchTarget = 0; ID_Jump = 0; ID_JumpTarget = 0;
      Halt = 0; Resume = 0;
   endtask

   task automatic cyc();
      @(posedge Clk); #1;
   endtask

   // Leaves the bench just after a clock edge with reset released and inputs idle.
   task automatic do_reset();
      cyc();
      clear_inputs();
      Reset = 1; #2; Reset = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      Reset = 1; clear_inputs(); PCResult = 32'h100;
      EX_MemRead = 1; EX_Rt = 5; ID_Rs = 5; Halt = 1;
      @(negedge Clk);
      asserts++; if (o1 !== 53'd0) begin fails++; $display("FAIL reset_l1: got %h expected %h", o1, 53'd0); end
      asserts++; if (o3 !== 53'd0) begin fails++; $display("FAIL reset_l3: got %h expected %h", o3, 53'd0); end
      cyc(); clear_inputs(); Reset = 0;
      @(negedge Clk);
      asserts++; if (o1 !== {32'h104, 5'b00000, 16'd0}) begin fails++; $display("FAIL post_reset_seq: got %h expected %h", o1, {32'h104, 5'b00000, 16'd0}); end
   endtask

   task automatic test_sequential();
      do_reset();
      PCResult = 32'h100;
      @(negedge Clk);
      asserts++; if (o1 !== {32'h104, 5'b00000, 16'd0}) begin fails++; $display("FAIL seq_100: got %h expected %h", o1, {32'h104, 5'b00000, 16'd0}); end
      cyc(); PCResult = 32'hFFFF_FFFC;
      @(negedge Clk);
      asserts++; if (o3 !== {32'h0, 5'b00000, 16'd0}) begin fails++; $display("FAIL seq_wrap: got %h expected %h", o3, {32'h0, 5'b00000, 16'd0}); end
   endtask

   task automatic test_load_stall();
      do_reset();
      PCResult = 32'h200; EX_MemRead = 1; EX_Rt = 5; ID_Rs = 5;
      @(negedge Clk);
      asserts++; if (o1 !== {32'h200, 5'b11010, 16'd0}) begin fails++; $display("FAIL stall_l1_c0: got %h expected %h", o1, {32'h200, 5'b11010, 16'd0}); end
      asserts++; if (o3 !== {32'h200, 5'b11010, 16'd0}) begin fails++; $display("FAIL stall_l3_c0: got %h expected %h", o3, {32'h200, 5'b11010, 16'd0}); end
      // Hazard gone; a jump arrives that the 3-cycle instance must ignore.
      cyc(); EX_MemRead = 0; EX_Rt = 0; ID_Rs = 0; ID_Jump = 1; ID_JumpTarget = 32'h400;
      @(negedge Clk);
      asserts++; if (o1 !== {32'h400, 5'b00100, 16'd1}) begin fails++; $display("FAIL stall_l1_c1: got %h expected %h", o1, {32'h400, 5'b00100, 16'd1}); end
      asserts++; if (o3 !== {32'h200, 5'b11010, 16'd1}) begin fails++; $display("FAIL stall_l3_c1: got %h expected %h", o3, {32'h200, 5'b11010, 16'd1}); end
      cyc();
      @(negedge Clk);
      asserts++; if (o3 !== {32'h200, 5'b11010, 16'd2}) begin fails++; $display("FAIL stall_l3_c2: got %h expected %h", o3, {32'h200, 5'b11010, 16'd2}); end
      cyc(); ID_Jump = 0;
      @(negedge Clk);
      asserts++; if (o1 !== {32'h204, 5'b00000, 16'd1}) begin fails++; $display("FAIL stall_l1_done: got %h expected %h", o1, {32'h204, 5'b00000, 16'd1}); end
      asserts++; if (o3 !== {32'h204, 5'b00000, 16'd3}) begin fails++; $display("FAIL stall_l3_done: got %h expected %h", o3, {32'h204, 5'b00000, 16'd3}); end
      // A load to register 0 never stalls.
      cyc(); EX_MemRead = 1; EX_Rt = 0; ID_Rs = 0;
      @(negedge Clk);
      asserts++; if (o1 !== {32'h204, 5'b00000, 16'd1}) begin fails++; $display("FAIL rt0_l1: got %h expected %h", o1, {32'h204, 5'b00000, 16'd1}); end
      asserts++; if (o3 !== {32'h204, 5'b00000, 16'd3}) begin fails++; $display("FAIL rt0_l3: got %h expected %h", o3, {32'h204, 5'b00000, 16'd3}); end
      // Rt match only counts when the ID instruction reads Rt.
      cyc(); EX_Rt = 7; ID_Rs = 1; ID_Rt = 7; ID_UsesRt = 0;
      @(negedge Clk);
      asserts++; if (o1 !== {32'h204, 5'b00000, 16'd1}) begin fails++; $display("FAIL rt_unused: got %h expected %h", o1, {32'h204, 5'b00000, 16'd1}); end
      cyc(); clear_inputs();
   endtask

   task automatic test_priority();
      do_reset();
      PCResult = 32'h100; ID_Jump = 1; ID_JumpTarget = 32'h400;
      ID_BranchTaken = 1; ID_BranchTarget = 32'h200;
      @(negedge Clk);
      asserts++; if (o1 !== {32'h400, 5'b00100, 16'd0}) begin fails++; $display("FAIL jump_over_branch: got %h expected %h", o1, {32'h400, 5'b00100, 16'd0}); end
      cyc(); ID_Jump = 0;
      @(negedge Clk);
      asserts++; if (o3 !== {32'h200, 5'b00100, 16'd0}) begin fails++; $display("FAIL branch_taken: got %h expected %h", o3, {32'h200, 5'b00100, 16'd0}); end
      cyc(); ID_Jump = 1; EX_MemRead = 1; EX_Rt = 9; ID_Rs = 3; ID_Rt = 9; ID_UsesRt = 1;
      @(negedge Clk);
      asserts++; if (o1 !== {32'h100, 5'b11010, 16'd0}) begin fails++; $display("FAIL hazard_over_jump: got %h expected %h", o1, {32'h100, 5'b11010, 16'd0}); end
      cyc(); clear_inputs();
   endtask

   task automatic test_halt();
      do_reset();
      PCResult = 32'h300; Halt = 1;
      @(negedge Clk);
      asserts++; if (o1 !== {32'h300, 5'b11010, 16'd0}) begin fails++; $display("FAIL halt_enter: got %h expected %h", o1, {32'h300, 5'b11010, 16'd0}); end
      cyc(); Resume = 1;
      @(negedge Clk);
      asserts++; if (o3 !== {32'h300, 5'b11011, 16'd0}) begin fails++; $display("FAIL halt_hold: got %h expected %h", o3, {32'h300, 5'b11011, 16'd0}); end
      cyc(); Halt = 0;
      @(negedge Clk);
      asserts++; if (o1 !== {32'h300, 5'b11011, 16'd0}) begin fails++; $display("FAIL halt_still_in_resume_cycle: got %h expected %h", o1, {32'h300, 5'b11011, 16'd0}); end
      cyc(); Resume = 0;
      @(negedge Clk);
      asserts++; if (o3 !== {32'h304, 5'b00000, 16'd0}) begin fails++; $display("FAIL halt_resumed: got %h expected %h", o3, {32'h304, 5'b00000, 16'd0}); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      PCResult = 32'h500; EX_MemRead = 1; EX_Rt = 4; ID_Rs = 4;
      cyc(); clear_inputs();
      // 3-cycle instance is now mid-STALL.
      #1 Reset = 1;
      #1;
      asserts++; if (o3 !== 53'd0) begin fails++; $display("FAIL reset_mid_stall: got %h expected %h", o3, 53'd0); end
      #1 Reset = 0;
      @(negedge Clk);
      asserts++; if (o3 !== {32'h504, 5'b00000, 16'd0}) begin fails++; $display("FAIL after_reset_stall: got %h expected %h", o3, {32'h504, 5'b00000, 16'd0}); end
      cyc(); Halt = 1;
      cyc(); Halt = 0;
      #1 Reset = 1;
      #1;
      asserts++; if (o1 !== 53'd0) begin fails++; $display("FAIL reset_mid_halt: got %h expected %h", o1, 53'd0); end
      #1 Reset = 0;
      @(negedge Clk);
      asserts++; if (o1 !== {32'h504, 5'b00000, 16'd0}) begin fails++; $display("FAIL after_reset_halt: got %h expected %h", o1, {32'h504, 5'b00000, 16'd0}); end
   endtask

   task automatic test_random();
      logic [52:0] e1, e3;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         PCResult        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom} & 32'hFFFF_FFFC;
         EX_MemRead      = ($urandom_range(0, 1) == 1);
         EX_Rt           = 5'($urandom_range(0, 3));
         ID_Rs           = 5'($urandom_range(0, 3));
         ID_Rt           = 5'($urandom_range(0, 3));
         ID_UsesRt       = ($urandom_range(0, 1) == 1);
         ID_Jump         = ($urandom_range(0, 3) == 0);
         ID_JumpTarget   = $urandom;
         ID_BranchTaken  = ($urandom_range(0, 3) == 0);
         ID_BranchTarget = $urandom;
         Halt            = ($urandom_range(0, 9) == 0);
         Resume          = ($urandom_range(0, 2) == 0);
         @(negedge Clk);
         e1 = expect_out(0);
         e3 = expect_out(1);
         asserts++; if (o1 !== e1) begin fails++; $display("FAIL rand_l1 cycle %0d: got %h expected %h", n, o1, e1); end
         asserts++; if (o3 !== e3) begin fails++; $display("FAIL rand_l3 cycle %0d: got %h expected %h", n, o3, e3); end
         cyc();
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_load_stall();
      test_priority();
      test_halt();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
